// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out an amount in 10/5/1 NIS coins, one coin per
// accepted handshake, with every output driven straight from a register.
module change_dispenser #(
    parameter int AMOUNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                change_req,
    input  logic [AMOUNT_W-1:0] change_amount,
    input  logic                coin_ack,
    output logic                coin_valid,
    output logic [3:0]          coin_out,
    output logic                busy,
    output logic                done,
    output logic [AMOUNT_W-1:0] coin_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t              state;
    logic [AMOUNT_W-1:0] remaining;
    logic [AMOUNT_W-1:0] remaining_after;
    logic [AMOUNT_W-1:0] coin_count_inc;

    // Largest coin that still fits, so the subtraction below can never wrap.
    function automatic logic [3:0] pick_coin(input logic [AMOUNT_W-1:0] rem);
        if (rem >= AMOUNT_W'(10)) begin
            return 4'd10;
        end else if (rem >= AMOUNT_W'(5)) begin
            return 4'd5;
        end else begin
            return 4'd1;
        end
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the missing case.
    always_comb begin
        remaining_after = remaining - AMOUNT_W'(coin_out);
        coin_count_inc  = coin_count + AMOUNT_W'(1);
    end

    // The next coin is computed from the next remaining value, so coin_out is a
    // register yet still tracks the greedy choice for the current remaining.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            coin_count <= '0;
            coin_valid <= 1'b0;
            coin_out   <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (change_req) begin
                        coin_count <= '0;
                        busy       <= 1'b1;
                        if (change_amount != '0) begin
                            state      <= DISPENSE;
                            remaining  <= change_amount;
                            coin_valid <= 1'b1;
                            coin_out   <= pick_coin(change_amount);
                        end else begin
                            state      <= DONE;
                            remaining  <= '0;
                            done       <= 1'b1;
                        end
                    end
                end

                DISPENSE: begin
                    if (coin_ack) begin
                        remaining  <= remaining_after;
                        coin_count <= coin_count_inc;
                        if (remaining_after == '0) begin
                            state      <= DONE;
                            coin_valid <= 1'b0;
                            coin_out   <= 4'd0;
                            done       <= 1'b1;
                        end else begin
                            coin_out <= pick_coin(remaining_after);
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    coin_valid <= 1'b0;
                    coin_out   <= 4'd0;
                end

                default: begin
                    state      <= IDLE;
                    remaining  <= '0;
                    coin_valid <= 1'b0;
                    coin_out   <= 4'd0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: inputs change on the falling edge and
// outputs are compared there too, half a cycle after the rising edge.
module tb_change_dispenser;

    localparam int AMOUNT_W = 8;

    logic                clk;
    logic                rst_n;
    logic                change_req;
    logic [AMOUNT_W-1:0] change_amount;
    logic                coin_ack;
    logic                coin_valid;
    logic [3:0]          coin_out;
    logic                busy;
    logic                done;
    logic [AMOUNT_W-1:0] coin_count;

    int n_cmp;
    int n_err;

    change_dispenser #(.AMOUNT_W(AMOUNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .change_req    (change_req),
        .change_amount (change_amount),
        .coin_ack      (coin_ack),
        .coin_valid    (coin_valid),
        .coin_out      (coin_out),
        .busy          (busy),
        .done          (done),
        .coin_count    (coin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_coin(input string tag, input int value);
        check({tag, "_valid"}, 32'(coin_valid), 32'd1);
        check({tag, "_coin"}, 32'(coin_out), 32'(value));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_nodone"}, 32'(done), 32'd0);
    endtask

    task automatic check_done(input string tag, input int count);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid0"}, 32'(coin_valid), 32'd0);
        check({tag, "_coin0"}, 32'(coin_out), 32'd0);
        check({tag, "_count"}, 32'(coin_count), 32'(count));
        step();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold_count"}, 32'(coin_count), 32'(count));
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        change_req    = 1'b0;
        change_amount = '0;
        coin_ack      = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 32'(coin_valid), 32'd0);
        check("rst_coin", 32'(coin_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(coin_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // coin_ack while idle is ignored
        coin_ack = 1'b1;
        step();
        step();
        check("idle_ack_valid", 32'(coin_valid), 32'd0);
        check("idle_ack_busy", 32'(busy), 32'd0);

        // Amount 17, ack held: 10,5,1,1 then done
        change_amount = 8'd17;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        check_coin("a17_c0", 10);
        step();
        check_coin("a17_c1", 5);
        check("a17_cnt1", 32'(coin_count), 32'd1);
        step();
        check_coin("a17_c2", 1);
        step();
        check_coin("a17_c3", 1);
        check("a17_cnt3", 32'(coin_count), 32'd3);
        step();
        check_done("a17", 4);

        // Amount 0: no coin, done in the next cycle
        coin_ack      = 1'b0;
        change_amount = 8'd0;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        check("a0_busy", 32'(busy), 32'd1);
        check_done("a0", 0);

        // Amount 10, ack low three cycles: coin held stable four cycles
        change_amount = 8'd10;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_coin("a10_hold", 10);
            check("a10_cnt0", 32'(coin_count), 32'd0);
            if (i == 3) coin_ack = 1'b1;
            step();
        end
        check_done("a10", 1);

        // Amount 255: 25 tens then one five
        change_amount = 8'd255;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        for (int i = 0; i < 25; i++) begin
            check_coin("a255_ten", 10);
            step();
        end
        check_coin("a255_five", 5);
        check("a255_cnt25", 32'(coin_count), 32'd25);
        step();
        check_done("a255", 26);

        // Amount 23 with a request of 5 raised mid-sequence
        change_amount = 8'd23;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        check_coin("a23_c0", 10);
        step();
        check_coin("a23_c1", 10);
        change_amount = 8'd5;
        change_req    = 1'b1;
        step();
        check_coin("a23_c2", 1);
        step();
        check_coin("a23_c3", 1);
        change_req = 1'b0;
        step();
        check_coin("a23_c4", 1);
        step();
        // Request raised in the DONE cycle is ignored too
        change_req = 1'b1;
        check_done("a23", 5);
        change_req = 1'b0;
        check("a23_ign_valid", 32'(coin_valid), 32'd0);
        step();
        check("a23_ign_busy", 32'(busy), 32'd0);
        check("a23_ign_done", 32'(done), 32'd0);

        // Reset after the first ack of 17 aborts without a done pulse
        change_amount = 8'd17;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        check_coin("rs_c0", 10);
        step();
        check_coin("rs_c1", 5);
        check("rs_cnt1", 32'(coin_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", 32'(coin_valid), 32'd0);
        check("rs_async_coin", 32'(coin_out), 32'd0);
        check("rs_async_busy", 32'(busy), 32'd0);
        check("rs_async_done", 32'(done), 32'd0);
        check("rs_async_count", 32'(coin_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rs_after_done", 32'(done), 32'd0);
        check("rs_after_busy", 32'(busy), 32'd0);

        // Fresh request of 6 after reset: 5 then 1
        change_amount = 8'd6;
        change_req    = 1'b1;
        step();
        change_req = 1'b0;
        check_coin("a6_c0", 5);
        step();
        check_coin("a6_c1", 1);
        step();
        check_done("a6", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: AMOUNT_W, default 8, width of change amount and coin count in NIS.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 change_req  input  1  request to dispense change_amount; sampled only in IDLE.
REQ-005 change_amount  input  AMOUNT_W  change owed in NIS, unsigned.
REQ-006 coin_ack  input  1  coin mechanism accepted the presented coin this cycle.
REQ-007 coin_valid  output  1  a coin is presented on coin_out.
REQ-008 coin_out  output  4  coin denomination in NIS: 4'd1, 4'd5 or 4'd10 (same encoding as the coin validator's coin_value); 4'd0 when coin_valid=0.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when a request completes.
REQ-011 coin_count  output  AMOUNT_W  number of coins accepted for the current or most recent request.

Function
REQ-012 The FSM SHALL have states IDLE, DISPENSE and DONE.
REQ-013 The block SHALL hold a registered remaining counter of AMOUNT_W bits.
REQ-014 IDLE, change_req=1, change_amount>0 -> load remaining=change_amount, clear coin_count to 0, next state DISPENSE.
REQ-015 IDLE, change_req=1, change_amount=0 -> clear coin_count, next state DONE, no coin presented.
REQ-016 IDLE, change_req=0 -> stay in IDLE.
REQ-017 change_req while busy=1 SHALL be ignored, with no effect on remaining, coin_count or state.
REQ-018 In DISPENSE, coin_valid SHALL be 1.
REQ-019 In DISPENSE, coin_out SHALL be chosen greedily from registered remaining only: 10 if remaining>=10, else 5 if remaining>=5, else 1.
REQ-020 There SHALL be no combinational path from any input to coin_valid, coin_out, busy or done.
REQ-021 Handshake: while coin_valid=1 and coin_ack=0, coin_out and remaining SHALL hold stable.
REQ-022 coin_ack while coin_valid=0 SHALL be ignored.
REQ-023 On coin_valid=1 and coin_ack=1 the block SHALL set remaining -= coin_out and coin_count += 1.
REQ-024 After an acked coin, next state SHALL be DONE if the new remaining is 0, else DISPENSE.
REQ-025 Back-to-back acks SHALL dispense one coin per cycle.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; a change_req in that DONE cycle is ignored.
REQ-027 Latency: change_req at edge N gives coin_valid=1 from cycle N+1; with amount 0, done=1 in cycle N+1.
REQ-028 A request SHALL complete with done=1 in the cycle after the final ack.
REQ-029 The greedy rule SHALL yield coin_count = amount/10 + (amount%10)/5 + amount%5, with sum of accepted coins exactly equal to the amount.
REQ-030 Arithmetic SHALL never underflow remaining; coin_out is always <= remaining in DISPENSE.
REQ-031 coin_count SHALL hold its value in IDLE until the next accepted request.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, remaining=0, coin_count=0, coin_valid=0, coin_out=0, busy=0 and done=0, regardless of clk.
REQ-033 Reset mid-DISPENSE SHALL abort the request with no done pulse; after release the block accepts a new request normally.

Verification
REQ-034 amount 17, coin_ack held 1 -> coin_out 10,5,1,1 on four consecutive cycles; done one cycle later; coin_count=4.
REQ-035 amount 0 -> coin_valid never 1; done=1 in the cycle after the request; coin_count=0.
REQ-036 amount 10, coin_ack low 3 cycles then high -> coin_out=10 stable for all 4 cycles; one coin; done next cycle.
REQ-037 amount 255 (AMOUNT_W=8), ack always 1 -> 25 coins of 10 then one 5; coin_count=26; done once.
REQ-038 amount 23 dispensing, change_req with amount 5 asserted mid-sequence -> ignored; sequence 10,10,1,1,1 unchanged.
REQ-039 rst_n pulsed low after the first ack of amount 17 -> outputs zero asynchronously, no done; then a new amount 6 -> coins 5,1 and done.
